// File: rtl/game_state_link_tx.sv
// game_state_link_tx: snapshots the authoritative game state on each tick edge and sends it
// to the slave board as a 9-byte 8N1 packet (sync, health, winner, sprites, XOR checksum).
module game_state_link_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_send_req,
    input  logic [8:0] i_health_1,
    input  logic [8:0] i_health_2,
    input  logic [2:0] i_winner,
    input  logic [6:0] i_sprite1_x,
    input  logic [6:0] i_sprite1_y,
    input  logic [6:0] i_sprite2_x,
    input  logic [6:0] i_sprite2_y,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic [7:0] o_drop_count
);
    localparam int            TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BYTE = 4'd8;
    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_START   = 2'd1;
    localparam logic [1:0]    S_DATA    = 2'd2;
    localparam logic [1:0]    S_STOP    = 2'd3;

    logic             r_req_meta;
    logic             r_req_sync;
    logic             r_req_prev;
    logic [1:0]       r_state;
    logic [TW-1:0]    r_timer;
    logic [2:0]       r_bit_idx;
    logic [3:0]       r_byte_idx;
    logic [8:0][7:0]  r_pkt;
    logic             r_tx;
    logic             r_frame_done;
    logic [7:0]       r_drop_count;

    logic             w_req;
    logic             w_accept;
    logic             w_drop;
    logic             w_wrap;
    logic             w_frame_end;
    logic [1:0]       w_state_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic [2:0]       w_bit_nxt;
    logic [3:0]       w_byte_nxt;
    logic             w_tx_nxt;
    logic [7:0]       w_b3;
    logic [7:0]       w_csum;
    logic [8:0][7:0]  w_pkt;
    logic [7:0]       w_cur_byte;

    // Request qualification happens after the synchroniser, so enable gates the clean edge.
    assign w_req       = r_req_sync & ~r_req_prev & i_enable;
    assign w_accept    = w_req & (r_state == S_IDLE);
    assign w_drop      = w_req & (r_state != S_IDLE);
    assign w_wrap      = (r_timer == T_LAST);
    assign w_frame_end = (r_state == S_STOP) & w_wrap & (r_byte_idx == LAST_BYTE);
    assign w_timer_nxt = ((r_state == S_IDLE) || w_wrap) ? '0 : r_timer + 1'b1;

    assign w_b3   = {1'b0, i_winner, 2'b00, i_health_2[8], i_health_1[8]};
    assign w_csum = i_health_1[7:0] ^ i_health_2[7:0] ^ w_b3 ^ {1'b0, i_sprite1_x}
                  ^ {1'b0, i_sprite1_y} ^ {1'b0, i_sprite2_x} ^ {1'b0, i_sprite2_y};
    assign w_pkt  = {w_csum, {1'b0, i_sprite2_y}, {1'b0, i_sprite2_x}, {1'b0, i_sprite1_y},
                     {1'b0, i_sprite1_x}, w_b3, i_health_2[7:0], i_health_1[7:0], SYNC_BYTE};

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_idx;
        case (r_state)
            S_IDLE: if (w_req) begin
                w_state_nxt = S_START;
                w_bit_nxt   = '0;
                w_byte_nxt  = '0;
            end
            S_START: if (w_wrap) begin
                w_state_nxt = S_DATA;
                w_bit_nxt   = '0;
            end
            S_DATA: if (w_wrap) begin
                w_state_nxt = (r_bit_idx == 3'd7) ? S_STOP : S_DATA;
                w_bit_nxt   = r_bit_idx + 3'd1;
            end
            default: if (w_wrap) begin
                w_state_nxt = (r_byte_idx == LAST_BYTE) ? S_IDLE : S_START;
                w_byte_nxt  = (r_byte_idx == LAST_BYTE) ? r_byte_idx : r_byte_idx + 4'd1;
            end
        endcase
    end

    // The line level is registered from next-state so the pin never glitches between bits.
    assign w_cur_byte = r_pkt[r_byte_idx];
    assign w_tx_nxt   = (w_state_nxt == S_START) ? 1'b0 :
                        (w_state_nxt == S_DATA)  ? w_cur_byte[w_bit_nxt] : 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_req_meta   <= 1'b0;
            r_req_sync   <= 1'b0;
            r_req_prev   <= 1'b0;
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_tx         <= 1'b1;
            r_frame_done <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_req_meta   <= i_send_req;
            r_req_sync   <= r_req_meta;
            r_req_prev   <= r_req_sync;
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_byte_idx   <= w_byte_nxt;
            r_tx         <= w_tx_nxt;
            r_frame_done <= w_frame_end;
            if (w_drop && (r_drop_count != 8'hFF))
                r_drop_count <= r_drop_count + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept)
            r_pkt <= w_pkt;
    end

    assign o_tx         = r_tx;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_frame_done;
    assign o_drop_count = r_drop_count;
endmodule

// File: tb/tb_game_state_link_tx.sv
// tb_game_state_link_tx: randomized bench; a packet-level model predicts accepted packets,
// their bytes, drops and frame timing, and a UART decoder recovers what the DUT sent.
module tb_game_state_link_tx;
    localparam int CPB = 4;
    localparam int L   = 90 * CPB;
    localparam int MID = CPB / 2;
    localparam logic [7:0] NOM [9] = '{8'hA5, 8'h2C, 8'h2D, 8'h21, 8'h0A, 8'h30, 8'h50, 8'h30, 8'h7A};

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       send_req;
    logic [8:0] health_1;
    logic [8:0] health_2;
    logic [2:0] winner;
    logic [6:0] sprite1_x;
    logic [6:0] sprite1_y;
    logic [6:0] sprite2_x;
    logic [6:0] sprite2_y;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [7:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int m_busy_end = 0;
    int m_drop = 0;
    int m_acc = 0;
    int acc_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    int fd_cnt = 0;
    int dec_cnt = -1;
    logic [7:0] dec_sr = '0;
    int busy_run = 0;

    game_state_link_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_send_req(send_req),
        .i_health_1(health_1), .i_health_2(health_2), .i_winner(winner),
        .i_sprite1_x(sprite1_x), .i_sprite1_y(sprite1_y),
        .i_sprite2_x(sprite2_x), .i_sprite2_y(sprite2_y),
        .o_tx(tx), .o_busy(busy), .o_frame_done(frame_done), .o_drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Expected bytes derived arithmetically from the field values present at the accept edge.
    function automatic void push_packet();
        int b[9];
        int cs;
        int h1;
        int h2;
        h1 = int'(health_1);
        h2 = int'(health_2);
        b[0] = 165;
        b[1] = h1 % 256;
        b[2] = h2 % 256;
        b[3] = int'(winner) * 16 + (h2 / 256) * 2 + h1 / 256;
        b[4] = int'(sprite1_x);
        b[5] = int'(sprite1_y);
        b[6] = int'(sprite2_x);
        b[7] = int'(sprite2_y);
        cs = 0;
        for (int i = 1; i < 8; i++) cs = cs ^ b[i];
        b[8] = cs;
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(b[i]));
    endfunction

    always @(posedge clk) begin
        if (acc_q.size() > 0 && acc_q[0] == cyc + 1) begin
            void'(acc_q.pop_front());
            push_packet();
        end
        cyc++;
    end

    task automatic got_byte(input logic [7:0] b);
        logic [7:0] e;
        log_q.push_back(b);
        check("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("byte_value", b, e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            dec_cnt = -1;
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            else if (busy_run > 0) begin
                check("busy_len", busy_run, L);
                busy_run = 0;
            end
            if (frame_done) begin
                fd_cnt++;
                check("fd_busy", busy, 0);
            end
            if (dec_cnt < 0) begin
                if (tx == 1'b0) dec_cnt = 0;
            end else begin
                dec_cnt++;
                if (dec_cnt == MID) check("start_bit", tx, 0);
                else if (dec_cnt == MID + 9 * CPB) begin
                    check("stop_bit", tx, 1);
                    got_byte(dec_sr);
                    dec_cnt = -1;
                end else if (dec_cnt > MID && (dec_cnt - MID) % CPB == 0)
                    dec_sr[(dec_cnt - MID) / CPB - 1] = tx;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Rising edge now reaches the FSM two edges later and is acted on at the third.
    task automatic pulse(input int hold);
        int rc;
        rc = cyc + 2;
        if (enable) begin
            if (rc < m_busy_end) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else begin
                acc_q.push_back(rc + 1);
                m_busy_end = rc + 1 + L;
                m_acc++;
            end
        end
        send_req = 1'b1;
        step(hold);
        send_req = 1'b0;
    endtask

    task automatic wait_done();
        if (m_busy_end + 3 > cyc) step(m_busy_end + 3 - cyc);
        check("idle_busy", busy, 0);
        check("all_bytes_seen", exp_q.size(), 0);
        check("frames_done", fd_cnt, m_acc);
        check("drop_model", drop_count, m_drop);
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        acc_q.delete();
        exp_q.delete();
        if (cyc < m_busy_end) m_acc--;
        m_busy_end = 0;
        m_drop = 0;
    endtask

    task automatic set_state(input int h1, input int h2, input int w, input int ax, input int ay,
                             input int bx, input int by);
        health_1 = 9'(h1);
        health_2 = 9'(h2);
        winner = 3'(w);
        sprite1_x = 7'(ax);
        sprite1_y = 7'(ay);
        sprite2_x = 7'(bx);
        sprite2_y = 7'(by);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int c0;
        logic any_busy;
        logic any_tx0;
        reset = 1'b0;
        enable = 1'b1;
        send_req = 1'b0;
        set_state(0, 0, 0, 0, 0, 0, 0);
        step(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_fd", frame_done, 0);
        check("rst_drop", drop_count, 0);
        reset = 1'b1;
        step(2);

        set_state(300, 45, 2, 10, 48, 80, 48);
        log_q.delete();
        pulse(2);
        step(1);
        check("accept_busy", busy, 1);
        check("accept_tx", tx, 0);
        wait_done();
        check("nom_count", log_q.size(), 9);
        for (int i = 0; i < 9; i++) check("nom_byte", log_q[i], NOM[i]);

        log_q.delete();
        c0 = cyc;
        pulse(2);
        step(c0 + 3 + 20 * CPB + 10 - cyc);
        health_1 = 9'd0;
        wait_done();
        check("snap_b1", log_q[1], 8'h2C);
        check("snap_csum", log_q[8], 8'h7A);
        log_q.delete();
        pulse(2);
        wait_done();
        check("next_b1", log_q[1], 8'h00);

        log_q.delete();
        pulse(2);
        step(20);
        repeat (3) begin
            pulse(2);
            step(30);
        end
        wait_done();
        check("ovr_drop", drop_count, 3);
        check("ovr_bytes", log_q.size(), 9);

        enable = 1'b0;
        step(3);
        any_busy = 1'b0;
        any_tx0 = 1'b0;
        repeat (5) begin
            pulse(2);
            repeat (4) begin
                step(1);
                if (busy) any_busy = 1'b1;
                if (!tx) any_tx0 = 1'b1;
            end
        end
        check("en_busy", any_busy, 0);
        check("en_tx", any_tx0, 0);
        check("en_drop", drop_count, 3);
        enable = 1'b1;
        step(3);
        log_q.delete();
        pulse(2);
        step(100);
        enable = 1'b0;
        wait_done();
        check("en_mid_bytes", log_q.size(), 9);
        enable = 1'b1;
        step(3);

        c0 = cyc;
        pulse(2);
        a = c0 + 3;
        step(a + 16 * 10 + CPB + 3 * CPB + 1 - cyc);
        assert_reset();
        step(1);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drop", drop_count, 0);
        step(1);
        reset = 1'b1;
        step(3);
        log_q.delete();
        pulse(2);
        wait_done();
        check("post_rst_sync", log_q[0], 8'hA5);
        check("post_rst_bytes", log_q.size(), 9);

        log_q.delete();
        c0 = cyc;
        pulse(2);
        a = c0 + 3;
        step(a + L - 2 - cyc);
        pulse(2);
        check("bnd_fd", frame_done, 1);
        check("bnd_idle", busy, 0);
        step(1);
        check("bnd_tx", tx, 0);
        check("bnd_busy", busy, 1);
        wait_done();
        check("bnd_drop", drop_count, 0);
        check("bnd_bytes", log_q.size(), 18);

        repeat (300) begin
            pulse(2);
            step(2);
        end
        wait_done();
        check("sat_drop", drop_count, 255);

        assert_reset();
        step(2);
        reset = 1'b1;
        step(3);
        repeat (40) begin
            set_state($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 7),
                      $urandom_range(0, 127), $urandom_range(0, 127),
                      $urandom_range(0, 127), $urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            step(3);
            pulse($urandom_range(1, 3));
            step($urandom_range(2, 150));
            health_2 = 9'($urandom_range(0, 511));
            sprite1_x = 7'($urandom_range(0, 127));
            step($urandom_range(1, 150));
        end
        enable = 1'b1;
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/game_state_link_tx.md
Name: game_state_link_tx

Overview:
- Master-side transmitter that sends the authoritative game state back to the slave board.
- The existing player-2 button wires carry input from slave to master. This block carries the result in the other direction: health, winner and sprite positions.
- It snapshots the state on each game tick, serialises it as a 9-byte UART-style packet (8N1, LSB first) and drives it on one Pmod pin.
- A slave-side receiver (separate block) decodes the packet so the slave OLED mirrors the master.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200 baud); must be >= 2.
- SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-low reset.
- enable  input  1  1 = accept new send requests; 0 = ignore requests (a frame in flight still completes).
- send_req  input  1  level signal, typically CLK_20Hz; a rising edge requests one packet.
- health_1  input  9  player 1 health.
- health_2  input  9  player 2 health.
- winner  input  3  game state / winner code.
- sprite1_x, sprite1_y, sprite2_x, sprite2_y  input  7 each  sprite coordinates.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a packet is being shifted out.
- frame_done  output  1  one-cycle pulse when the last stop bit completes.
- drop_count  output  8  saturating count of requests lost because busy was high.

Behaviour:
- Reset applies when reset==0 at a clk edge. After reset: tx=1, busy=0, frame_done=0, drop_count=0, FSM=IDLE, send_req edge register=0.
- Reset mid-packet aborts immediately. tx=1 from the next cycle; no partial byte completes.
- Edge detection:
  - prev_req is registered every cycle.
  - A request is the cycle where send_req=1 and prev_req=0 (registered) and enable=1.
  - send_req is synchronised internally with a 2-flop synchroniser before edge detection.
- Accept (request while FSM=IDLE):
  - Snapshot all state inputs into a packet register on the same clk edge.
  - Go to START; busy=1 and tx=0 from the next cycle.
  - Later input changes do not affect the packet in flight.
- Request while busy: ignored; drop_count increments, holding at 255.
- Request with enable=0: ignored; not counted.
- Packet bytes, in order:
  - B0 = SYNC_BYTE.
  - B1 = health_1[7:0].
  - B2 = health_2[7:0].
  - B3 = {1'b0, winner[2:0], 2'b00, health_2[8], health_1[8]}.
  - B4 = {0, sprite1_x}.
  - B5 = {0, sprite1_y}.
  - B6 = {0, sprite2_x}.
  - B7 = {0, sprite2_y}.
  - B8 = B1^B2^B3^B4^B5^B6^B7 (XOR checksum; SYNC excluded).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte index < 8: increment and go to START (no idle gap between bytes). If byte index == 8: go to IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps. The byte index (4-bit, 0..8) and bit index (3-bit) advance only on timer wrap.
- Packet length is exactly 90*CLKS_PER_BIT cycles of busy=1.
- Completion cycle (first IDLE cycle):
  - busy=0 and frame_done=1 on that cycle, for one cycle only.
  - A new request seen on that cycle is accepted; it is not counted as dropped.
- A request arriving on the exact cycle busy falls is accepted (IDLE evaluation takes priority over the drop path).
- No back-to-back queuing: at most one packet in flight; no pending-request buffer.

Test Plan:
- Nominal packet. CLKS_PER_BIT=4; health_1=300, health_2=45, winner=3'b010, sprite1=(10,48), sprite2=(80,48); one send_req edge.
  - tx decodes to A5 2C 2D 21 0A 30 50 30 7A.
  - busy high for exactly 360 cycles; one frame_done pulse.
- Snapshot stability. Same setup; change health_1 to 0 during byte B2.
  - Packet still carries B1=2C and checksum 7A.
  - The next packet carries B1=00.
- Overrun. Issue 3 send_req edges during one packet.
  - drop_count=3; only one packet on tx.
  - Saturation: after 300 dropped edges, drop_count=255.
- Enable gating. enable=0 with 5 send_req edges: tx stays 1, busy=0, drop_count unchanged.
  - Deassert enable mid-packet: that packet completes fully.
- Reset mid-packet. Assert reset during B4, bit 3.
  - Next cycle: tx=1, busy=0, drop_count=0.
  - After reset is released, the next edge yields a complete, correct packet starting with A5.
- Boundary edge. Raise send_req on the frame_done cycle.
  - A new packet starts: tx=0 on the following cycle.
  - drop_count unchanged; the gap between packets is exactly 1 idle cycle.
